// File: rtl/overlay_sequencer.sv
// overlay_sequencer: time-shares the VGA text-overlay path among several
// banner generators. One banner is shown for SHOW_FRAMES frames with a
// horizontal scroll, then the overlay is blanked for BLANK_FRAMES frames
// before the next banner is selected. The overlay pixel from the selected
// generator is gated and registered for the colour mixer.
module overlay_sequencer #(
    parameter int NUM_BANNERS  = 4,
    parameter int SHOW_FRAMES  = 120,
    parameter int BLANK_FRAMES = 30,
    parameter int SCROLL_STEP  = 1,
    parameter int X_RANGE      = 640
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   frame_tick,
    input  logic                   skip,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   video_active,
    input  logic [NUM_BANNERS-1:0] ov_in,
    output logic [9:0]             x_scrolled,
    output logic [9:0]             y_pass,
    output logic [2:0]             sel,
    output logic                   overlay_out,
    output logic                   showing
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;

    localparam logic [7:0]  SHOW_LAST  = 8'(SHOW_FRAMES - 1);
    localparam logic [7:0]  BLANK_LAST = 8'(BLANK_FRAMES - 1);
    localparam logic [2:0]  SEL_LAST   = 3'(NUM_BANNERS - 1);
    localparam logic [10:0] STEP11     = 11'(SCROLL_STEP);
    localparam logic [10:0] RANGE11    = 11'(X_RANGE);

    logic [1:0]  r_state;
    logic [2:0]  r_sel;
    logic [7:0]  r_frame_cnt;
    logic [9:0]  r_x_off;
    logic        r_overlay;

    logic [2:0]  w_sel_next;
    logic [10:0] w_x_sum;
    logic [9:0]  w_x_next;
    logic        w_ov_bit;

    // Next banner index with wrap from the last banner back to banner 0.
    assign w_sel_next = (r_sel == SEL_LAST) ? 3'd0 : (r_sel + 3'd1);

    // Scroll offset advance; the sum is one bit wider so the wrap test sees
    // the true value before the X_RANGE subtraction.
    assign w_x_sum  = {1'b0, r_x_off} + STEP11;
    assign w_x_next = (w_x_sum >= RANGE11) ? 10'(w_x_sum - RANGE11) : w_x_sum[9:0];

    // Pick the selected generator's overlay bit; an index with no banner reads 0.
    always_comb begin
        w_ov_bit = 1'b0;
        for (int i = 0; i < NUM_BANNERS; i++) begin
            if (r_sel == 3'(i)) begin
                w_ov_bit = ov_in[i];
            end
        end
    end

    // Banner sequencing FSM: disable beats skip, skip beats frame_tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sel       <= 3'd0;
            r_frame_cnt <= 8'd0;
            r_x_off     <= 10'd0;
        end else if (!enable) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= 8'd0;
            r_x_off     <= 10'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_SHOW;
                    r_sel       <= 3'd0;
                    r_frame_cnt <= 8'd0;
                    r_x_off     <= 10'd0;
                end
                S_SHOW: begin
                    if (skip) begin
                        r_state     <= S_SHOW;
                        r_sel       <= w_sel_next;
                        r_frame_cnt <= 8'd0;
                        r_x_off     <= 10'd0;
                    end else if (frame_tick) begin
                        r_x_off <= w_x_next;
                        if (r_frame_cnt == SHOW_LAST) begin
                            r_state     <= S_BLANK;
                            r_frame_cnt <= 8'd0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                end
                S_BLANK: begin
                    if (skip) begin
                        r_state     <= S_SHOW;
                        r_sel       <= w_sel_next;
                        r_frame_cnt <= 8'd0;
                        r_x_off     <= 10'd0;
                    end else if (frame_tick) begin
                        if (r_frame_cnt == BLANK_LAST) begin
                            r_state     <= S_SHOW;
                            r_sel       <= w_sel_next;
                            r_frame_cnt <= 8'd0;
                            r_x_off     <= 10'd0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_frame_cnt <= 8'd0;
                    r_x_off     <= 10'd0;
                end
            endcase
        end
    end

    // Registered overlay pixel, gated by visible area and the SHOW state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overlay <= 1'b0;
        end else begin
            r_overlay <= w_ov_bit & video_active & (r_state == S_SHOW);
        end
    end

    assign x_scrolled  = x - r_x_off;
    assign y_pass      = y;
    assign sel         = r_sel;
    assign overlay_out = r_overlay;
    assign showing     = (r_state == S_SHOW);

endmodule

// File: tb/tb_overlay_sequencer.sv
// Bench for overlay_sequencer: directed steps followed by random stimulus,
// all compared against an event-counting reference model.
module tb_overlay_sequencer;

  localparam int NB    = 2;
  localparam int SHOWF = 3;
  localparam int BLNKF = 2;
  localparam int STEP  = 7;
  localparam int XR    = 20;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          frame_tick;
  logic          skip;
  logic [9:0]    x;
  logic [9:0]    y;
  logic          video_active;
  logic [NB-1:0] ov_in;
  logic [9:0]    x_scrolled;
  logic [9:0]    y_pass;
  logic [2:0]    sel;
  logic          overlay_out;
  logic          showing;

  int checks;
  int failures;

  // reference model: banner index plus ticks counted since that banner began
  bit m_active;
  int m_banner;
  int m_ticks;
  bit m_ov;

  overlay_sequencer #(
    .NUM_BANNERS (NB),
    .SHOW_FRAMES (SHOWF),
    .BLANK_FRAMES(BLNKF),
    .SCROLL_STEP (STEP),
    .X_RANGE     (XR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .frame_tick  (frame_tick),
    .skip        (skip),
    .x           (x),
    .y           (y),
    .video_active(video_active),
    .ov_in       (ov_in),
    .x_scrolled  (x_scrolled),
    .y_pass      (y_pass),
    .sel         (sel),
    .overlay_out (overlay_out),
    .showing     (showing)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_showing();
    return m_active && (m_ticks < SHOWF);
  endfunction

  function automatic int m_xoff();
    int shown;
    if (!m_active) return 0;
    shown = (m_ticks < SHOWF) ? m_ticks : SHOWF;
    return (shown * STEP) % XR;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [9:0] ex_xs;
    ex_xs = x - 10'(m_xoff());
    chk("sel", 16'(sel), 16'(m_banner));
    chk("showing", 16'(showing), 16'(m_showing()));
    chk("overlay_out", 16'(overlay_out), 16'(m_ov));
    chk("x_scrolled", 16'(x_scrolled), 16'(ex_xs));
    chk("y_pass", 16'(y_pass), 16'(y));
  endtask

  task automatic model_reset();
    m_active = 0;
    m_banner = 0;
    m_ticks  = 0;
    m_ov     = 0;
  endtask

  // one clock edge: update the model from pre-edge inputs, then compare
  task automatic cycle();
    @(posedge clk);
    m_ov = m_showing() && video_active && ov_in[m_banner];
    if (!enable) begin
      m_active = 0;
      m_ticks  = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_banner = 0;
      m_ticks  = 0;
    end else if (skip) begin
      m_banner = (m_banner + 1) % NB;
      m_ticks  = 0;
    end else if (frame_tick) begin
      m_ticks++;
      if (m_ticks == SHOWF + BLNKF) begin
        m_banner = (m_banner + 1) % NB;
        m_ticks  = 0;
      end
    end
    #1;
    check_model();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    reset = 1'b1;
    enable = 1'b0;
    frame_tick = 1'b0;
    skip = 1'b0;
    x = 10'd0;
    y = 10'd33;
    video_active = 1'b0;
    ov_in = '0;

    // reset state
    #12;
    check_model();
    chk("reset_showing", 16'(showing), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle();
    chk("idle_after_release", 16'(showing), 16'd0);

    // enable -> SHOW with banner 0
    enable = 1'b1;
    cycle();
    chk("enter_show", 16'(showing), 16'd1);
    chk("enter_sel", 16'(sel), 16'd0);
    chk("enter_ov", 16'(overlay_out), 16'd0);

    // three ticks end SHOW; x_off = 21 mod 20 = 1
    tick(); tick(); tick();
    chk("blank_after_show", 16'(showing), 16'd0);
    chk("scroll_wrap", 16'(x_scrolled), 16'd1023);
    tick();
    chk("still_blank", 16'(showing), 16'd0);
    tick();
    chk("next_banner_show", 16'(showing), 16'd1);
    chk("next_banner_sel", 16'(sel), 16'd1);
    chk("next_banner_xoff", 16'(x_scrolled), 16'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("banner_wrap_sel", 16'(sel), 16'd0);
    chk("banner_wrap_show", 16'(showing), 16'd1);

    // skip together with frame_tick: skip wins
    tick();
    chk("one_tick_scroll", 16'(x_scrolled), 16'd1017);
    skip = 1'b1;
    frame_tick = 1'b1;
    cycle();
    skip = 1'b0;
    frame_tick = 1'b0;
    chk("skip_sel", 16'(sel), 16'd1);
    chk("skip_show", 16'(showing), 16'd1);
    chk("skip_xoff", 16'(x_scrolled), 16'd0);

    // pixel gating with banner 1 selected
    ov_in = 2'b10;
    video_active = 1'b1;
    cycle();
    cycle();
    chk("gate_on", 16'(overlay_out), 16'd1);
    video_active = 1'b0;
    cycle();
    chk("gate_video_off", 16'(overlay_out), 16'd0);
    video_active = 1'b1;
    tick(); tick(); tick();
    cycle();
    chk("gate_blank", 16'(overlay_out), 16'd0);

    // async reset between edges while in BLANK
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_model();
    chk("async_sel", 16'(sel), 16'd0);
    chk("async_showing", 16'(showing), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle();
    chk("sel0_show", 16'(showing), 16'd1);
    cycle();
    chk("gate_sel0", 16'(overlay_out), 16'd0);

    // skip in IDLE is ignored
    skip = 1'b1;
    enable = 1'b0;
    cycle();
    cycle();
    skip = 1'b0;
    chk("idle_skip_show", 16'(showing), 16'd0);
    chk("idle_skip_sel", 16'(sel), 16'd0);

    // disable with simultaneous frame_tick
    enable = 1'b1;
    tick(); tick();
    x = 10'd5;
    enable = 1'b0;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    chk("disable_showing", 16'(showing), 16'd0);
    chk("disable_xoff", 16'(x_scrolled), 16'd5);

    // randomized stimulus
    for (int n = 0; n < 3000; n++) begin
      enable       = ($urandom_range(0, 63) != 0);
      frame_tick   = ($urandom_range(0, 3) == 0);
      skip         = ($urandom_range(0, 39) == 0);
      video_active = 1'($urandom_range(0, 1));
      ov_in        = NB'($urandom);
      x            = 10'($urandom);
      y            = 10'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/overlay_sequencer.md
Name: overlay_sequencer

Overview:
- Frame-rate controller that time-shares the VGA text-overlay path among NUM_BANNERS bitmap text generators.
- Selects one banner at a time, shows it for SHOW_FRAMES frames, blanks for BLANK_FRAMES frames, then advances to the next banner.
- Produces horizontally scrolled pixel coordinates for the text generators and a registered, gated overlay pixel for the colour mixer.
- Sits between the VGA timing generator and the text_* bitmap blocks.

Parameters:
NUM_BANNERS, 4, number of text generators sharing the overlay (2..8)
SHOW_FRAMES, 120, frames a banner is visible (1..255)
BLANK_FRAMES, 30, frames of blank gap between banners (1..255)
SCROLL_STEP, 1, pixels the x offset advances per shown frame (0..15; 0 = static)
X_RANGE, 640, x offset wraps modulo this value (1..1023)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; 0 forces IDLE
frame_tick  in  1  single-cycle pulse at start of vertical blanking
skip  in  1  single-cycle pulse; advance to next banner immediately
x  in  10  current pixel column from timing generator
y  in  10  current pixel row from timing generator
video_active  in  1  1 inside the visible area
ov_in  in  NUM_BANNERS  overlay_active bits from the text generators (bit i = banner i)
x_scrolled  out  10  x - x_off (mod 1024), combinational, fed to the text generators
y_pass  out  10  y unchanged, combinational
sel  out  3  index of the current banner
overlay_out  out  1  registered gated overlay pixel
showing  out  1  1 while state == SHOW

Behaviour:
- Reset values: state=IDLE, sel=0, x_off=0, frame_cnt=0, overlay_out=0, showing=0.
- States: IDLE, SHOW, BLANK. Transitions are evaluated only on clk edges.
- IDLE -> SHOW when enable=1. Entering SHOW from IDLE sets sel=0, x_off=0, frame_cnt=0.
- Any state -> IDLE when enable=0, in the same edge. This clears frame_cnt and x_off. sel holds its value, but it is overwritten on re-entry.
- SHOW, on frame_tick:
  - If frame_cnt == SHOW_FRAMES-1, go to BLANK with frame_cnt=0.
  - Otherwise frame_cnt+1.
  - x_off advances on every SHOW frame_tick, including the last, as (x_off + SCROLL_STEP) mod X_RANGE. The wrap is computed in 11 bits, then X_RANGE is subtracted if the result >= X_RANGE.
- BLANK, on frame_tick:
  - If frame_cnt == BLANK_FRAMES-1, go to SHOW with frame_cnt=0, x_off=0, and sel=(sel+1) mod NUM_BANNERS.
  - Otherwise frame_cnt+1. x_off holds.
- skip pulse in SHOW or BLANK: next edge enters SHOW with sel=(sel+1) mod NUM_BANNERS, frame_cnt=0, x_off=0.
- skip in IDLE is ignored.
- Simultaneous skip and frame_tick: skip wins and the frame_tick is discarded for that cycle.
- Simultaneous enable falling with skip or frame_tick: IDLE wins.
- Banner wrap: sel = NUM_BANNERS-1 advances to 0.
- overlay_out, 1-cycle latency: overlay_out(n+1) = ov_in[sel](n) & video_active(n) & (state(n)==SHOW).
  - Uses the sel and state in effect during cycle n.
  - Out-of-range sel cannot occur; if it did, it would read as 0.
- showing = (state==SHOW), registered state output with no extra delay.
- x_scrolled = x - x_off, 10-bit modulo subtraction, combinational.
- y_pass = y.
- Reset asserted mid-frame forces all reset values asynchronously. After release, the block stays in IDLE for at least one edge, then resumes per enable.
- frame_tick is assumed single-cycle. A multi-cycle tick counts once per high cycle; no edge detection is performed.

Test Plan:
- Reset/enable: SHOW_FRAMES=3, BLANK_FRAMES=2, NUM_BANNERS=2. Assert reset, release, enable=1 -> next edge state SHOW, sel=0, showing=1, overlay_out=0.
- Full cycle, same parameters: 3 frame_ticks -> BLANK; 2 more -> SHOW with sel=1; 5 more -> SHOW with sel=0 (wrap). showing low for exactly 2 frame intervals each time.
- Scroll wrap: SCROLL_STEP=7, X_RANGE=20, SHOW_FRAMES=10. After 3 ticks x_off=1 (21 mod 20). With x=0, x_scrolled=1023.
- Skip priority: in SHOW with frame_cnt=1, pulse skip and frame_tick together -> SHOW, sel+1, frame_cnt=0, x_off=0. Skip in IDLE -> no change.
- Pixel gating: ov_in=2'b10, sel=1, video_active=1 in SHOW -> overlay_out=1 one cycle later. Under each of video_active=0, state BLANK, or sel=0 -> overlay_out=0 one cycle later.
- Async reset / disable mid-run: assert reset between clock edges in BLANK -> outputs at reset values immediately without a clock. Separately, drop enable with a simultaneous frame_tick -> IDLE, x_off=0, showing=0.
